// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg: state encoding and default timing constants shared by the
// stopwatch front-end. Optional LAP feature: STOPWATCH_LAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_TIMING = 2'd1;
  localparam logic [1:0] ST_STOP   = 2'd2;
  localparam logic [1:0] ST_LAP    = 2'd3;

  localparam int DEF_TICK_DIV  = 500000;
  localparam int DEF_DB_CYCLES = 1000000;

  // LAP only counts when it is a reachable state.
  function automatic logic is_counting(input logic [1:0] st);
`ifdef STOPWATCH_LAP_EN
    return (st == ST_TIMING) || (st == ST_LAP);
`else
    return (st == ST_TIMING);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce: 2-flop synchroniser, stability filter and single-cycle press
// pulse on the filtered 0->1 edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press_p
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q,  sync_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], key_raw};
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle where the synchronised input agrees with the level restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_p = pulse_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_sequencer.sv
// ============================================================================
// stopwatch_sequencer: debounced start/stop and lap/reset keys drive a
// four-state controller and a gated time-base prescaler.
// Optional LAP state and hold output: STOPWATCH_LAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_ss,
  input  logic               key_lr,
  output logic               clr,
  output logic               count,
  output logic               hold,
  output logic               tick,
  output logic [STATE_W-1:0] state
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          ss_p, lr_p;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_ss),
    .press_p (ss_p)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_lr),
    .press_p (lr_p)
  );

  // ss_p is tested first everywhere, so a simultaneous lr_p is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        if (ss_p) state_d = ST_TIMING;
      end
      ST_TIMING: begin
        if (ss_p) state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lr_p) state_d = ST_LAP;
`endif
      end
      ST_STOP: begin
        if (ss_p)      state_d = ST_TIMING;
        else if (lr_p) state_d = ST_RESET;
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (ss_p)      state_d = ST_STOP;
        else if (lr_p) state_d = ST_TIMING;
      end
`endif
      default: state_d = ST_RESET;
    endcase
  end

  // Prescaler freezes outside the counting states so a resume keeps the fraction.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_q == ST_RESET) begin
      presc_d = '0;
    end else if (count) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign state = state_q;
  assign clr   = (state_q == ST_RESET);
  assign count = is_counting(state_q);
  // A strobe registered on the edge that leaves a counting state is suppressed here.
  assign tick  = tick_q & count;
`ifdef STOPWATCH_LAP_EN
  assign hold  = (state_q == ST_LAP);
`else
  assign hold  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_sequencer.sv
// ============================================================================
// tb_stopwatch_sequencer: directed key sequences with a scoreboard of expected
// state changes and tick strobes (TICK_DIV=4, DB_CYCLES=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;

  logic       clk;
  logic       reset;
  logic       key_ss;
  logic       key_lr;
  logic       clr;
  logic       count;
  logic       hold;
  logic       tick;
  logic [1:0] state;

  stopwatch_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_ss (key_ss),
    .key_lr (key_lr),
    .clr    (clr),
    .count  (count),
    .hold   (hold),
    .tick   (tick),
    .state  (state)
  );

  typedef struct {
    int         kind;    // 0 = key press, 1 = async reset pulse
    bit         ss;
    bit         lr;
    bit         bounce;
    logic [1:0] st;      // state expected once the step has taken effect
    int         idle;
  } step_t;

  typedef struct {
    int         cyc;     // -1: cycle not checked
    logic [1:0] st;
  } sev_t;

  step_t steps[$];
  sev_t  st_q[$];
  int    tk_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit counting(input logic [1:0] st);
    return (st == 2'd1) || (st == 2'd3);
  endfunction

  // ---------------- monitor ----------------
  logic [4:0] prev_out;
  bit         first = 1'b1;

  always @(negedge clk) begin
    logic [4:0] cur;
    sev_t       e;
    int         t;
    cur = {state, clr, count, hold};
    if (first || cur != prev_out) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL state_event: unexpected change at cycle %0d to state=%0d clr=%0b count=%0b hold=%0b",
                 cyc, state, clr, count, hold);
      end else begin
        e = st_q.pop_front();
        if ((e.cyc >= 0 && e.cyc != cyc) || state !== e.st || clr !== (e.st == 2'd0) ||
            count !== counting(e.st) || hold !== (e.st == 2'd3)) begin
          errors++;
          $display("FAIL state_event: got cycle %0d state=%0d clr=%0b count=%0b hold=%0b, expected cycle %0d state=%0d clr=%0b count=%0b hold=%0b",
                   cyc, state, clr, count, hold, e.cyc, e.st, (e.st == 2'd0), counting(e.st), (e.st == 2'd3));
        end
      end
    end
    prev_out = cur;
    first    = 1'b0;
    if (tick !== 1'b0) begin
      checks++;
      if (tk_q.size() == 0) begin
        errors++;
        $display("FAIL tick_event: unexpected tick at cycle %0d (count=%0b), expected none", cyc, count);
      end else begin
        t = tk_q.pop_front();
        if (t != cyc || count !== 1'b1) begin
          errors++;
          $display("FAIL tick_event: got tick at cycle %0d count=%0b, expected cycle %0d count=1", cyc, count, t);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic add(input int kind, input bit ss, input bit lr, input bit bounce,
                     input logic [1:0] st, input int idle);
    step_t s;
    s.kind = kind; s.ss = ss; s.lr = lr; s.bounce = bounce; s.st = st; s.idle = idle;
    steps.push_back(s);
  endtask

  function automatic int edge_of(input step_t s, input int p);
    if (s.kind == 1) return p;
    return p + (s.bounce ? 4 : 0) + DB_CYCLES + 3;
  endfunction

  initial begin
    step_t      s, n;
    sev_t       ev;
    logic [1:0] cur_st;
    int         p, pc, e_i, pn, en, dur;
    bit         vis;

    reset  = 1'b1;
    key_ss = 1'b0;
    key_lr = 1'b0;
    ev.cyc = -1; ev.st = 2'd0;
    st_q.push_back(ev);

    add(0, 1, 0, 1, 2'd1, 3);   // bounced start
`ifdef STOPWATCH_LAP_EN
    add(0, 0, 1, 0, 2'd3, 5);   // lap
    add(0, 0, 1, 0, 2'd1, 2);   // lap release
`else
    add(0, 0, 1, 0, 2'd1, 5);   // lap key ignored while timing
    add(0, 0, 1, 0, 2'd1, 2);
`endif
    add(0, 1, 0, 0, 2'd2, 7);   // stop
    add(0, 1, 0, 0, 2'd1, 1);   // resume from frozen prescaler
    add(0, 1, 1, 0, 2'd2, 0);   // simultaneous: start/stop wins
    add(0, 0, 1, 0, 2'd0, 3);   // stop -> reset
    add(0, 1, 0, 0, 2'd1, 6);   // start
    add(1, 0, 0, 0, 2'd0, 3);   // async reset mid-timing
    add(0, 1, 0, 0, 2'd1, 4);   // prescaler restarts from 0
    add(0, 1, 0, 0, 2'd2, 0);
    add(0, 0, 1, 0, 2'd0, 5);
    add(0, 0, 1, 0, 2'd0, 2);   // lap/reset ignored in RESET

    repeat (3) wait_neg();
    reset = 1'b0;
    repeat (5) wait_neg();

    cur_st = 2'd0;
    pc     = 0;
    for (int i = 0; i < steps.size(); i++) begin
      p = cyc;
      s = steps[i];
      e_i = edge_of(s, p);
      if (s.st != cur_st) begin
        ev.cyc = (s.kind == 1) ? p + 1 : e_i;
        ev.st  = s.st;
        st_q.push_back(ev);
      end
      dur = (s.kind == 1) ? 4 : (s.bounce ? 4 : 0) + 20;
      pn  = p + dur + s.idle;
      if (i + 1 < steps.size()) begin
        n   = steps[i + 1];
        en  = edge_of(n, pn);
        vis = (n.kind == 1) || counting(n.st);
      end else begin
        en  = pn;
        vis = 1'b0;
      end
      // Expected strobes for the interval this step opens.
      if (counting(s.st)) begin
        for (int t = e_i + 1; t <= en; t++) begin
          if (pc == TICK_DIV - 1) begin
            pc = 0;
            if (t < en || vis) tk_q.push_back(t);
          end else begin
            pc++;
          end
        end
      end else if (s.st == 2'd0) begin
        pc = 0;
      end
      cur_st = s.st;

      if (s.kind == 1) begin
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || clr !== 1'b1 || count !== 1'b0 || hold !== 1'b0 || tick !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: got state=%0d clr=%0b count=%0b hold=%0b tick=%0b, expected 0 1 0 0 0",
                   state, clr, count, hold, tick);
        end
        wait_neg();
        wait_neg();
        reset = 1'b0;
        wait_neg();
        wait_neg();
      end else begin
        if (s.bounce) begin
          for (int b = 0; b < 4; b++) begin
            key_ss = s.ss & ~b[0];
            key_lr = s.lr & ~b[0];
            wait_neg();
          end
        end
        key_ss = s.ss;
        key_lr = s.lr;
        repeat (8) wait_neg();
        key_ss = 1'b0;
        key_lr = 1'b0;
        repeat (12) wait_neg();
      end
      repeat (s.idle) wait_neg();
    end

    repeat (10) wait_neg();
    checks++;
    if (st_q.size() != 0) begin
      errors++;
      $display("FAIL pending_state: got %0d unobserved state events, expected 0 (next cycle %0d)",
               st_q.size(), st_q[0].cyc);
    end
    checks++;
    if (tk_q.size() != 0) begin
      errors++;
      $display("FAIL pending_tick: got %0d unobserved ticks, expected 0 (next cycle %0d)",
               tk_q.size(), tk_q[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
